// File: rtl/flash_sector.sv
// rtl/flash_sector.sv - on-chip flash array with read/program/erase command controller
module flash_sector #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 10,
  parameter int SECTOR_W    = 6,
  parameter int PROG_CYCLES = 4
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic              erase_en,
  input  logic              erase_all,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] idata,
  output logic [DATA_W-1:0] odata,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int PCW   = $clog2(PROG_CYCLES + 1);

  // Erase lengths carry one extra bit so a whole-chip count fits without wrapping.
  localparam logic [ADDR_W:0]   CHIP_LEN  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   SECT_LEN  = (ADDR_W + 1)'(1 << SECTOR_W);
  localparam logic [ADDR_W-1:0] SECT_MASK = ADDR_W'((1 << SECTOR_W) - 1);
  localparam logic [PCW-1:0]    PROG_LAST = PCW'(PROG_CYCLES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PROG  = 2'd1;
  localparam logic [1:0] ST_ERASE = 2'd2;

  // Non-volatile array: never reset, only changed by program/erase.
  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic [1:0]        state;
  logic [PCW-1:0]    prog_cnt;
  logic [ADDR_W:0]   erase_cnt;
  logic [ADDR_W:0]   erase_len;
  logic [ADDR_W-1:0] op_addr;    // program target, or erase base address
  logic [DATA_W-1:0] prog_data;

  logic              any_cmd;
  logic              word_erased;
  logic              prog_last;
  logic              erase_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign any_cmd     = rd_en | wr_en | erase_en;
  assign word_erased = (mem[addr] == '0);
  assign prog_last   = (state == ST_PROG) && (prog_cnt == PROG_LAST);
  assign erase_last  = (erase_cnt == erase_len - (ADDR_W + 1)'(1));
  assign busy        = (state != ST_IDLE);

  // Single array write port; reset blocks the write so an interrupted op leaves no partial word.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = op_addr;
    mem_wdata = '0;
    if (!RST) begin
      if (prog_last) begin
        mem_we    = 1'b1;
        mem_wdata = prog_data;
      end else if (state == ST_ERASE) begin
        mem_we    = 1'b1;
        mem_waddr = op_addr + erase_cnt[ADDR_W-1:0];
      end
    end
  end

  // Array write, one word per cycle.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Command controller: accept in IDLE, run program/erase sequences, flag commands while busy.
  always_ff @(posedge clk) begin
    if (RST) begin
      state     <= ST_IDLE;
      odata     <= '0;
      rd_valid  <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      prog_cnt  <= '0;
      erase_cnt <= '0;
      erase_len <= '0;
      op_addr   <= '0;
      prog_data <= '0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rd_en) begin
            odata    <= mem[addr];
            rd_valid <= 1'b1;
          end else if (wr_en) begin
            if (!word_erased) begin
              error <= 1'b1;
            end else begin
              op_addr   <= addr;
              prog_data <= idata;
              prog_cnt  <= '0;
              state     <= ST_PROG;
            end
          end else if (erase_en) begin
            op_addr   <= erase_all ? '0 : (addr & ~SECT_MASK);
            erase_len <= erase_all ? CHIP_LEN : SECT_LEN;
            erase_cnt <= '0;
            state     <= ST_ERASE;
          end
        end
        ST_PROG: begin
          error <= any_cmd;
          if (prog_last) begin
            prog_cnt <= '0;
            done     <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            prog_cnt <= prog_cnt + PCW'(1);
          end
        end
        ST_ERASE: begin
          error <= any_cmd;
          if (erase_last) begin
            erase_cnt <= '0;
            done      <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            erase_cnt <= erase_cnt + (ADDR_W + 1)'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_sector.sv
// tb/tb_flash_sector.sv - scoreboard testbench for flash_sector
module tb_flash_sector;

  localparam int PROG_CYCLES = 4;

  logic        clk = 1'b0;
  logic        RST;
  logic        rd_en;
  logic        wr_en;
  logic        erase_en;
  logic        erase_all;
  logic [9:0]  addr;
  logic [31:0] idata;
  logic [31:0] odata;
  logic        rd_valid;
  logic        busy;
  logic        done;
  logic        error;

  flash_sector #(
    .DATA_W(32), .ADDR_W(10), .SECTOR_W(6), .PROG_CYCLES(PROG_CYCLES)
  ) dut (
    .clk(clk), .RST(RST), .rd_en(rd_en), .wr_en(wr_en), .erase_en(erase_en),
    .erase_all(erase_all), .addr(addr), .idata(idata), .odata(odata),
    .rd_valid(rd_valid), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic        started = 1'b0;
  logic [31:0] model [0:1023];
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: each rd_valid pulse pops the oldest expected read value.
  always @(negedge clk) begin
    if (started && rd_valid) begin
      if (exp_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
      else check("rd_data", odata, exp_q.pop_front());
    end
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (busy && n < 5000) begin
      n++;
      tick;
    end
  endtask

  task automatic do_read(input logic [9:0] a);
    addr  = a;
    rd_en = 1'b1;
    exp_q.push_back(model[a]);
    tick;
    rd_en = 1'b0;
    check("rd_nobusy", busy, 32'd0);
  endtask

  task automatic do_prog(input logic [9:0] a, input logic [31:0] d, input logic ok);
    int n;
    addr  = a;
    idata = d;
    wr_en = 1'b1;
    tick;
    wr_en = 1'b0;
    if (ok) begin
      wait_busy(n);
      check("prog_busy_len", n, PROG_CYCLES);
      check("prog_done", done, 32'd1);
      model[a] = d;
    end else begin
      check("prog_err", error, 32'd1);
      check("prog_err_nobusy", busy, 32'd0);
      tick;
      check("prog_err_pulse", error, 32'd0);
    end
  endtask

  task automatic do_erase(input logic [9:0] a, input logic all, input int len);
    int n;
    int base;
    base      = all ? 0 : int'({a[9:6], 6'b0});
    addr      = a;
    erase_all = all;
    erase_en  = 1'b1;
    tick;
    erase_en  = 1'b0;
    erase_all = 1'b0;
    wait_busy(n);
    check("erase_busy_len", n, len);
    check("erase_done", done, 32'd1);
    tick;
    check("erase_done_pulse", done, 32'd0);
    for (int i = 0; i < len; i++) model[base + i] = 32'd0;
  endtask

  initial begin
    int n;
    RST = 1'b1; rd_en = 1'b0; wr_en = 1'b0; erase_en = 1'b0; erase_all = 1'b0;
    addr = '0; idata = '0;
    for (int i = 0; i < 1024; i++) model[i] = 32'd0;
    repeat (2) tick;
    check("rst_odata", odata, 32'd0);
    check("rst_rd_valid", rd_valid, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_done", done, 32'd0);
    check("rst_error", error, 32'd0);
    RST = 1'b0;
    started = 1'b1;

    // Establish a known erased array, then basic read
    do_erase(10'd0, 1'b1, 1024);
    do_read(10'd5);

    // Program, read back, re-program rejected
    do_prog(10'd5, 32'hDEADBEEF, 1'b1);
    do_read(10'd5);
    do_prog(10'd5, 32'h12345678, 1'b0);
    do_read(10'd5);

    // rd_en and wr_en together: read wins, no error, no program
    addr = 10'd7; idata = 32'h55; rd_en = 1'b1; wr_en = 1'b1;
    exp_q.push_back(model[7]);
    tick;
    rd_en = 1'b0; wr_en = 1'b0;
    check("rdwr_noerr", error, 32'd0);
    check("rdwr_nobusy", busy, 32'd0);
    tick;
    check("rdwr_noprog", busy, 32'd0);
    do_read(10'd7);

    // Chip erase then full readback
    do_erase(10'd3, 1'b1, 1024);
    for (int i = 0; i < 1024; i++) do_read(i[9:0]);

    // Fill with ones, sector erase around addr 70
    for (int i = 0; i < 1024; i++) do_prog(i[9:0], 32'hFFFF_FFFF, 1'b1);
    do_erase(10'd70, 1'b0, 64);
    for (int i = 0; i < 256; i++) do_read(i[9:0]);

    // Read attempted during erase: error, no data, erase length unaffected
    addr = 10'd200; erase_en = 1'b1;
    tick;
    erase_en = 1'b0;
    n = 0;
    while (busy && n < 5000) begin
      n++;
      rd_en = (n == 3);
      addr  = 10'd192;
      tick;
      if (n == 3) begin
        check("busy_rd_err", error, 32'd1);
        check("busy_rd_novalid", rd_valid, 32'd0);
      end
    end
    rd_en = 1'b0;
    check("busy_rd_erase_len", n, 32'd64);
    check("busy_rd_done", done, 32'd1);
    for (int i = 192; i < 256; i++) model[i] = 32'd0;
    do_read(10'd191);
    do_read(10'd200);
    do_read(10'd63);

    // Reset during the second program cycle: word stays erased
    addr = 10'd192; idata = 32'hAAAA_5555; wr_en = 1'b1;
    tick;
    wr_en = 1'b0;
    tick;
    RST = 1'b1;
    tick;
    RST = 1'b0;
    check("rstprog_busy", busy, 32'd0);
    check("rstprog_done", done, 32'd0);
    check("rstprog_odata", odata, 32'd0);
    check("rstprog_error", error, 32'd0);
    repeat (PROG_CYCLES) tick;
    check("rstprog_nodone", done, 32'd0);
    do_read(10'd192);

    // Reset at erase cycle 10 of sector 0: words 0..9 cleared only
    addr = 10'd5; erase_all = 1'b0; erase_en = 1'b1;
    tick;
    erase_en = 1'b0;
    repeat (10) tick;
    RST = 1'b1;
    tick;
    RST = 1'b0;
    check("rsterase_busy", busy, 32'd0);
    for (int i = 0; i < 10; i++) model[i] = 32'd0;
    for (int i = 0; i < 64; i++) do_read(i[9:0]);

    repeat (3) tick;
    check("rd_pending", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
